// File: rtl/alu_op_sequencer.sv
// Sweeps a boolean ALU through all select codes for one latched operand pair; first result HOLD cycles after start.
// No backpressure: start is ignored outside IDLE. Optional result signature on output sig under macro ALU_SIG_EN.
module alu_op_sequencer #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3,
  parameter int HOLD  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH:0]   alu_result,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [SEL_W-1:0] alu_select,
  output logic             res_valid,
  output logic [SEL_W-1:0] res_sel,
  output logic [WIDTH:0]   res_data,
  output logic             busy,
`ifdef ALU_SIG_EN
  output logic [WIDTH:0]   sig,
`endif
  output logic             done
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(HOLD - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [SEL_W-1:0] sel_q, sel_d, rsel_q, rsel_d;
  logic [WIDTH:0]   rdat_q, rdat_d;
  logic             rvld_q, rvld_d, busy_q, busy_d, done_q, done_d;
  logic [WIDTH:0]   sig_q, sig_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    sel_d   = sel_q;
    rsel_d  = rsel_q;
    rdat_d  = rdat_q;
    rvld_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sig_d   = sig_q;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          in1_d   = op_a;
          in2_d   = op_b;
          sel_d   = '0;
          cnt_d   = '0;
          sig_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // Abort wins over a capture falling on the same edge.
        if (abort) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          rvld_d = 1'b1;
          rdat_d = alu_result;
          rsel_d = sel_q;
          sig_d  = {sig_q[WIDTH-1:0], sig_q[WIDTH]} ^ alu_result;
          if (sel_q == '1) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            sel_d = sel_q + 1'b1;
            cnt_d = '0;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      sel_q   <= '0;
      rsel_q  <= '0;
      rdat_q  <= '0;
      rvld_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      sel_q   <= sel_d;
      rsel_q  <= rsel_d;
      rdat_q  <= rdat_d;
      rvld_q  <= rvld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sig_q   <= sig_d;
    end
  end

  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign alu_select = sel_q;
  assign res_valid  = rvld_q;
  assign res_sel    = rsel_q;
  assign res_data   = rdat_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef ALU_SIG_EN
  assign sig        = sig_q;
`endif

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the boolean ALU interface.
- Latches one operand pair on `start`, then drives `alu_select` through all 8 codes (0..7), holding each for HOLD cycles.
- Samples the ALU's 5-bit result at the end of each hold window and presents it on a registered result port with a one-cycle valid strobe.
- Sits between a control/test harness and a combinational boolean ALU instance.

Parameters:
- WIDTH, 4, operand width; the result is WIDTH+1 bits.
- SEL_W, 3, select width; the sequence length is 2**SEL_W.
- HOLD, 2, cycles each select code is held before sampling; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a sequence; honoured only in IDLE
- abort  input  1  synchronous cancel of a running sequence
- op_a  input  WIDTH  operand A, latched on accepted start
- op_b  input  WIDTH  operand B, latched on accepted start
- alu_result  input  WIDTH+1  combinational ALU output
- alu_in1  output  WIDTH  registered operand A to the ALU
- alu_in2  output  WIDTH  registered operand B to the ALU
- alu_select  output  SEL_W  registered select code to the ALU
- res_valid  output  1  one-cycle strobe; res_data/res_sel are valid
- res_sel  output  SEL_W  select code that produced res_data
- res_data  output  WIDTH+1  captured ALU result
- busy  output  1  high in DRIVE
- done  output  1  one-cycle pulse after the last capture

Behaviour:
- Clock and reset: one clock, `clk`. `rst` is asynchronous and active-high.
- Reset values: all outputs 0; state = IDLE; hold counter = 0.
- All outputs are registered; there is no combinational input-to-output path.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - busy=0.
  - start=1 → alu_in1<=op_a, alu_in2<=op_b, alu_select<=0, cnt<=0, go DRIVE.
  - alu_in1/alu_in2/alu_select otherwise hold their last values.
- DRIVE:
  - busy=1.
  - If cnt<HOLD-1: cnt<=cnt+1.
  - If cnt==HOLD-1 (capture edge): res_data<=alu_result, res_sel<=alu_select, res_valid<=1 for the next cycle only.
  - At the capture edge, if alu_select<2**SEL_W-1: alu_select<=alu_select+1, cnt<=0, stay in DRIVE.
  - At the capture edge, if alu_select==2**SEL_W-1: go DONE. alu_select holds at 7; no wrap to 0.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Latency:
  - First select is driven the cycle after start.
  - First res_valid appears HOLD cycles after start is sampled.
  - busy is high for exactly 8*HOLD cycles.
  - done is asserted in the same cycle as the final res_valid.
- start while busy or in DONE: ignored; latched operands are unchanged.
- abort in DRIVE:
  - Takes priority over capture in the same cycle.
  - Next state IDLE; no res_valid, no done.
  - alu_* outputs hold their values.
- abort in IDLE or DONE: no effect; DONE still completes to IDLE.
- start and abort together in IDLE: start is accepted.
- op_a/op_b changing during DRIVE: no effect on alu_in1/alu_in2.
- rst mid-sequence: immediate return to reset values; no done pulse.
- HOLD=1: capture on every DRIVE cycle; res_valid is high for 8 consecutive cycles.

Optional Feature:
- Macro: ALU_SIG_EN.
- With ALU_SIG_EN defined:
  - Adds output `sig`, WIDTH+1 bits, reset 0.
  - `sig` clears to 0 on accepted start.
  - On each capture edge: sig <= {sig[WIDTH-1:0], sig[WIDTH]} ^ alu_result.
  - Value is stable from the done pulse onward, until the next start.
  - abort leaves `sig` at its partial value.
- Without ALU_SIG_EN: no `sig` port and no signature logic; all other behaviour is identical.

Test Plan:
- Bench ALU stub: alu_result = alu_in1 + alu_in2 + alu_select, 5-bit.
- Basic run: HOLD=2, op_a=4'hA, op_b=4'h5, start pulse.
  - alu_select is 0 for 2 cycles, then increments every 2 cycles.
  - 8 res_valid strobes, res_sel 0..7, res_data 5'h0F..5'h16.
  - busy high for 16 cycles; done pulses once with res_sel=7.
- Start while busy: second start with op_a=4'h3 at cycle 5.
  - alu_in1 stays 4'hA; the sequence is unaffected.
  - Exactly 8 strobes and 1 done.
- Abort at alu_select=3, cnt=1 (capture cycle).
  - No res_valid for sel 3; only 3 strobes total (sels 0..2).
  - busy drops the next cycle; no done.
  - A subsequent start runs a full 8-strobe sequence.
- Async rst asserted mid-cycle during DRIVE with alu_select=5.
  - All outputs read 0 before the next clock edge.
  - No done pulse.
- HOLD=1, op_a=4'hF, op_b=4'hF.
  - res_valid high for 8 consecutive cycles; res_data 5'h1E..5'h25 truncated to 5 bits (0x1E, 0x1F, 0x00..0x05).
  - done coincides with the last strobe.
- ALU_SIG_EN defined, basic-run stimulus.
  - After done, sig equals the bench model's rotate-XOR of 5'h0F..5'h16.
  - A second start clears sig to 0 one cycle after start.
